// File: rtl/adder_pipe_if.sv
// Operand/result handshake bundle for adder_pipe.
// The master side drives operand beats and consumes results; slave is the adder.
interface adder_pipe_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             sub_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum_out;
  logic             carry_out;
  logic             ovf_out;
  logic             busy;

  modport master (
    output in_valid, a_in, b_in, sub_in, out_ready,
    input  in_ready, out_valid, sum_out, carry_out, ovf_out, busy
  );

  modport slave (
    input  in_valid, a_in, b_in, sub_in, out_ready,
    output in_ready, out_valid, sum_out, carry_out, ovf_out, busy
  );
endinterface

// File: rtl/adder_pipe.sv
// Pipelined add/subtract with carry/borrow and signed-overflow flags.
// Valid/ready flow control; empty stages accept even while downstream stalls.
module adder_pipe #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned STAGES   = 2,
  parameter int unsigned SAT_MODE = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  adder_pipe_if.slave bus
);

  localparam int unsigned XW   = WIDTH + 1;
  localparam int unsigned LAST = STAGES - 1;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;
  } res_t;

  logic [XW-1:0]     raw_c;
  logic              carry_c;
  logic              ovf_c;
  res_t              res0_c;
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] adv_c;
  logic [STAGES:0]   ld_c;
  res_t              d_q [STAGES];

  // Result of the beat presented on the bus; captured by stage 0.
  always_comb begin : compute
    raw_c   = '0;
    carry_c = 1'b0;
    ovf_c   = 1'b0;
    res0_c  = '0;
    if (bus.sub_in) begin
      raw_c   = {1'b0, bus.a_in} + {1'b0, ~bus.b_in} + XW'(1);
      carry_c = ~raw_c[WIDTH];
      ovf_c   = (bus.a_in[WIDTH-1] != bus.b_in[WIDTH-1]) &&
                (raw_c[WIDTH-1] != bus.a_in[WIDTH-1]);
    end else begin
      raw_c   = {1'b0, bus.a_in} + {1'b0, bus.b_in};
      carry_c = raw_c[WIDTH];
      ovf_c   = (bus.a_in[WIDTH-1] == bus.b_in[WIDTH-1]) &&
                (raw_c[WIDTH-1] != bus.a_in[WIDTH-1]);
    end
    res0_c.sum   = raw_c[WIDTH-1:0];
    res0_c.carry = carry_c;
    res0_c.ovf   = ovf_c;
    // Saturation clamps the value only; flags still report the raw event.
    if ((SAT_MODE != 0) && carry_c) begin
      res0_c.sum = bus.sub_in ? '0 : '1;
    end
  end

  // Load chain from the consumer back to the input; ld_c[STAGES] is the consumer.
  always_comb begin : handshake
    adv_c          = '0;
    ld_c           = '0;
    ld_c[STAGES]   = bus.out_ready;
    for (int k = int'(LAST); k >= 0; k--) begin
      adv_c[k] = v_q[k] && ld_c[k+1];
      ld_c[k]  = !v_q[k] || adv_c[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : stages
    if (!rst_n) begin
      v_q <= '0;
      for (int k = 0; k < int'(STAGES); k++) begin
        d_q[k] <= '0;
      end
    end else begin
      if (ld_c[0]) begin
        v_q[0] <= bus.in_valid;
        if (bus.in_valid) begin
          d_q[0] <= res0_c;
        end
      end
      for (int k = 1; k < int'(STAGES); k++) begin
        if (ld_c[k]) begin
          v_q[k] <= v_q[k-1];
          if (v_q[k-1]) begin
            d_q[k] <= d_q[k-1];
          end
        end
      end
    end
  end

  assign bus.in_ready  = ld_c[0];
  assign bus.out_valid = v_q[LAST];
  assign bus.sum_out   = d_q[LAST].sum;
  assign bus.carry_out = d_q[LAST].carry;
  assign bus.ovf_out   = d_q[LAST].ovf;
  assign bus.busy      = |v_q;

endmodule

// File: tb/tb_adder_pipe.sv
// Bench for adder_pipe: three instances (8b/2 stages wrap, 8b/2 stages saturate,
// 16b/4 stages wrap) driven in lockstep and checked against an arithmetic model.
module tb_adder_pipe;

  typedef struct packed {
    logic [15:0] sum;
    logic        carry;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] sum_w;
    logic [7:0] sum_s;
    logic       carry;
    logic       ovf;
  } vec_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        iv    = 1'b0;
  logic        ordy  = 1'b1;
  logic        sub   = 1'b0;
  logic [15:0] a     = '0;
  logic [15:0] b     = '0;
  int          checks = 0;
  int          errors = 0;
  exp_t        q0[$];
  exp_t        q1[$];
  exp_t        q2[$];

  always #5 clk = ~clk;

  adder_pipe_if #(.WIDTH(8))  ifc0 ();
  adder_pipe_if #(.WIDTH(8))  ifc1 ();
  adder_pipe_if #(.WIDTH(16)) ifc2 ();

  assign ifc0.in_valid = iv;   assign ifc1.in_valid = iv;   assign ifc2.in_valid = iv;
  assign ifc0.out_ready = ordy; assign ifc1.out_ready = ordy; assign ifc2.out_ready = ordy;
  assign ifc0.sub_in = sub;    assign ifc1.sub_in = sub;    assign ifc2.sub_in = sub;
  assign ifc0.a_in = a[7:0];   assign ifc1.a_in = a[7:0];   assign ifc2.a_in = a;
  assign ifc0.b_in = b[7:0];   assign ifc1.b_in = b[7:0];   assign ifc2.b_in = b;

  adder_pipe #(.WIDTH(8),  .STAGES(2), .SAT_MODE(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(ifc0));
  adder_pipe #(.WIDTH(8),  .STAGES(2), .SAT_MODE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(ifc1));
  adder_pipe #(.WIDTH(16), .STAGES(4), .SAT_MODE(0)) dut2 (.clk(clk), .rst_n(rst_n), .bus(ifc2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic exp_t model(input int w, input bit sat, input logic [15:0] x,
                                 input logic [15:0] y, input bit s);
    exp_t   r;
    longint mask, half, ux, uy, sx, sy, full, sr;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ux = longint'(x) & mask;
    uy = longint'(y) & mask;
    sx = (ux >= half) ? ux - (mask + 1) : ux;
    sy = (uy >= half) ? uy - (mask + 1) : uy;
    if (s) begin
      full    = ux - uy;
      r.carry = (ux < uy);
      sr      = sx - sy;
    end else begin
      full    = ux + uy;
      r.carry = (full > mask);
      sr      = sx + sy;
    end
    r.ovf = (sr >= half) || (sr < -half);
    r.sum = 16'(full & mask);
    if (sat && r.carry) r.sum = s ? 16'h0 : 16'(mask);
    return r;
  endfunction

  // Scoreboard: record accepted beats, compare each consumed result in order.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n) begin
      q0.delete(); q1.delete(); q2.delete();
    end else begin
      if (ifc0.out_valid && ordy) begin
        chk("sb0_pending", 32'(q0.size() > 0), 1);
        if (q0.size() > 0) begin
          e = q0.pop_front();
          chk("sb0", {ifc0.sum_out, ifc0.carry_out, ifc0.ovf_out}, {e.sum[7:0], e.carry, e.ovf});
        end
      end
      if (ifc1.out_valid && ordy) begin
        chk("sb1_pending", 32'(q1.size() > 0), 1);
        if (q1.size() > 0) begin
          e = q1.pop_front();
          chk("sb1", {ifc1.sum_out, ifc1.carry_out, ifc1.ovf_out}, {e.sum[7:0], e.carry, e.ovf});
        end
      end
      if (ifc2.out_valid && ordy) begin
        chk("sb2_pending", 32'(q2.size() > 0), 1);
        if (q2.size() > 0) begin
          e = q2.pop_front();
          chk("sb2", {ifc2.sum_out, ifc2.carry_out, ifc2.ovf_out}, {e.sum, e.carry, e.ovf});
        end
      end
      if (iv && ifc0.in_ready) q0.push_back(model(8, 1'b0, a, b, sub));
      if (iv && ifc1.in_ready) q1.push_back(model(8, 1'b1, a, b, sub));
      if (iv && ifc2.in_ready) q2.push_back(model(16, 1'b0, a, b, sub));
    end
  end

  task automatic drain();
    int n = 0;
    while ((ifc0.busy || ifc1.busy || ifc2.busy) && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_idle", {ifc0.busy, ifc1.busy, ifc2.busy}, 0);
  endtask

  task automatic beat(input logic [15:0] x, input logic [15:0] y, input logic s);
    a = x; b = y; sub = s; iv = 1'b1;
  endtask

  vec_t tv [8];

  initial begin
    tv[0] = '{8'h12, 8'h34, 1'b0, 8'h46, 8'h46, 1'b0, 1'b0};
    tv[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 8'hFF, 1'b1, 1'b0};
    tv[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 8'h80, 1'b0, 1'b1};
    tv[3] = '{8'h05, 8'h07, 1'b1, 8'hFE, 8'h00, 1'b1, 1'b0};
    tv[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 8'h7F, 1'b0, 1'b1};
    tv[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 8'hFF, 1'b1, 1'b1};
    tv[6] = '{8'h33, 8'h33, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0};
    tv[7] = '{8'h7F, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b1, 1'b1};

    // Reset state
    #45;
    chk("rst_flags0", {ifc0.out_valid, ifc0.busy, ifc0.in_ready, ifc0.carry_out, ifc0.ovf_out}, 5'b00100);
    chk("rst_flags1", {ifc1.out_valid, ifc1.busy, ifc1.in_ready, ifc1.carry_out, ifc1.ovf_out}, 5'b00100);
    chk("rst_flags2", {ifc2.out_valid, ifc2.busy, ifc2.in_ready, ifc2.carry_out, ifc2.ovf_out}, 5'b00100);
    chk("rst_sum", {ifc0.sum_out, ifc1.sum_out, ifc2.sum_out}, 0);
    #5;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed vectors: single beat, latency and value per table row
    for (int i = 0; i < 8; i++) begin
      int  lat;
      logic got;
      beat({8'h00, tv[i].a}, {8'h00, tv[i].b}, tv[i].sub);
      ordy = 1'b1;
      lat  = 0;
      got  = 1'b0;
      while (lat < 20 && !got) begin
        @(posedge clk); #1;
        iv  = 1'b0;
        lat++;
        got = ifc0.out_valid;
      end
      chk("vec_latency", 32'(lat), 2);
      chk("vec_wrap", {ifc0.out_valid, ifc0.sum_out, ifc0.carry_out, ifc0.ovf_out},
          {1'b1, tv[i].sum_w, tv[i].carry, tv[i].ovf});
      chk("vec_sat", {ifc1.out_valid, ifc1.sum_out, ifc1.carry_out, ifc1.ovf_out},
          {1'b1, tv[i].sum_s, tv[i].carry, tv[i].ovf});
      drain();
    end

    // Back-to-back random stream; out_valid must appear after STAGES and never gap
    for (int t = 0; t < 20; t++) begin
      if (t < 16) beat(16'($urandom), 16'($urandom), 1'($urandom));
      else iv = 1'b0;
      ordy = 1'b1;
      @(negedge clk);
      if (t < 16) chk("stream_in_ready", {ifc0.in_ready, ifc1.in_ready, ifc2.in_ready}, 3'b111);
      @(posedge clk); #1;
      chk("stream_ov_s2", {ifc0.out_valid, ifc1.out_valid},
          {2{(t + 1 >= 2) && (t + 1 - 2 < 16)}});
      chk("stream_ov_s4", ifc2.out_valid, 32'((t + 1 >= 4) && (t + 1 - 4 < 16)));
    end
    drain();

    // Stall with bubble collapse, held output, then release with simultaneous in/out
    beat(16'h12, 16'h34, 1'b0);
    ordy = 1'b0;
    @(negedge clk); chk("stall_rdy_a", ifc0.in_ready, 1);
    @(posedge clk); #1;
    beat(16'hFF, 16'h01, 1'b0);
    @(negedge clk); chk("stall_rdy_bubble", ifc0.in_ready, 1);
    @(posedge clk); #1;
    beat(16'h05, 16'h07, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall_rdy_full", ifc0.in_ready, 0);
      chk("stall_hold", {ifc0.out_valid, ifc0.sum_out, ifc0.carry_out, ifc0.ovf_out},
          {1'b1, 8'h46, 1'b0, 1'b0});
      @(posedge clk); #1;
    end
    ordy = 1'b1;
    @(negedge clk); chk("release_rdy", ifc0.in_ready, 1);
    @(posedge clk); #1;
    iv = 1'b0;
    chk("drain_b", {ifc0.out_valid, ifc0.sum_out, ifc0.carry_out, ifc0.ovf_out},
        {1'b1, 8'h00, 1'b1, 1'b0});
    @(posedge clk); #1;
    chk("drain_c", {ifc0.out_valid, ifc0.sum_out, ifc0.carry_out, ifc0.ovf_out},
        {1'b1, 8'hFE, 1'b1, 1'b0});
    @(posedge clk); #1;
    chk("drain_end", {ifc0.out_valid, ifc0.in_ready}, 2'b01);
    drain();

    // Asynchronous reset with two beats in flight
    beat(16'h10, 16'h20, 1'b0);
    @(posedge clk); #1;
    beat(16'h30, 16'h01, 1'b0);
    @(posedge clk); #1;
    iv = 1'b0;
    chk("pre_rst_inflight", {ifc0.busy, ifc0.out_valid}, 2'b11);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async", {ifc0.out_valid, ifc0.busy, ifc1.out_valid, ifc1.busy,
                      ifc2.out_valid, ifc2.busy}, 0);
    chk("rst_async_ready", {ifc0.in_ready, ifc0.sum_out}, {1'b1, 8'h00});
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      chk("post_rst_idle", {ifc0.out_valid, ifc1.out_valid, ifc2.out_valid, ifc2.busy}, 0);
    end

    // Fresh beat after reset still flows
    beat(16'h0102, 16'h0304, 1'b0);
    @(posedge clk); #1;
    iv = 1'b0;
    drain();
    chk("sb_empty", 32'(q0.size() + q1.size() + q2.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/adder_pipe.md
Name: adder_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle adder.
- Performs add or subtract on WIDTH-bit operands and returns carry/borrow and signed-overflow flags.
- Carries valid/ready flow control with per-stage bubble collapse.
- Sits between the stimulus/driver interface and any downstream consumer; the bench connects through an interface instance, as it does for the existing adder.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).
- STAGES, 2, pipeline depth in register stages (>=1); equals the no-stall latency.
- SAT_MODE, 0, 0 = wrap-around result; 1 = unsigned saturation of sum_out.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat present
- in_ready  output  1  block can accept operand beat this cycle
- a_in  input  WIDTH  operand A
- b_in  input  WIDTH  operand B
- sub_in  input  1  0 = A+B, 1 = A-B; sampled with the beat
- out_valid  output  1  result beat present
- out_ready  input  1  consumer accepts result this cycle
- sum_out  output  WIDTH  result
- carry_out  output  1  add: carry out of MSB; sub: borrow (1 when A<B unsigned)
- ovf_out  output  1  two's-complement signed overflow of the operation
- busy  output  1  any stage holds a valid beat

Behaviour:
- Reset (async assert, sync-released by the environment):
  - All stage valid bits clear; all stage data regs 0.
  - Outputs: out_valid=0, sum_out=0, carry_out=0, ovf_out=0, busy=0, in_ready=1.
- Transfers: an input beat transfers on in_valid&&in_ready at a clock edge; an output beat on out_valid&&out_ready.
- Compute in stage 0 from the registered beat inputs: WIDTH+1-bit result.
  - Add: {c,s}=A+B.
  - Sub: {c',s}=A+~B+1, borrow=~c'.
  - ovf: add = (A[msb]==B[msb])&&(s[msb]!=A[msb]); sub = (A[msb]!=B[msb])&&(s[msb]!=A[msb]).
- Saturation (SAT_MODE=1):
  - Add with carry gives sum_out = all ones.
  - Sub with borrow gives sum_out = 0.
  - carry_out/ovf_out still report the raw event.
  - With SAT_MODE=0, sum_out = s.
- Pipeline:
  - Stages 0..STAGES-1; stage STAGES-1 drives the out_* ports directly from registers (no combinational path from a_in/b_in to outputs).
  - Stage k loads when (!v[k] || adv[k]); adv[STAGES-1]=out_ready; adv[k]=v[k]&&loads[k+1].
  - in_ready = loads[0] (combinational from out_ready through the chain is permitted).
  - Bubbles collapse: an empty stage accepts even when downstream is stalled.
- Latency: exactly STAGES cycles from input transfer to out_valid when out_ready=1 continuously.
  - Sustained throughput is 1 beat/clock.
- Stall: with out_ready=0 and all STAGES stages valid, in_ready=0.
  - Held output data must remain stable while out_valid&&!out_ready.
- Ordering: results leave strictly in input order; no beat dropped or duplicated.
- Simultaneous in/out transfer on a full pipeline: allowed. The pipeline shifts, and the new beat enters stage 0 in the same edge.
- Data on a_in/b_in/sub_in is ignored when in_valid=0 or in_ready=0.
- Reset mid-operation: all in-flight beats discarded immediately; no out_valid after reset release until a new input transfer plus STAGES cycles.
- busy = OR of all stage valid bits.

Test Plan (WIDTH=8, STAGES=2 unless stated):
- Reset held 50 ns, then release; single beat A=8'h12, B=8'h34, add, out_ready=1 -> out_valid exactly 2 cycles later, sum=8'h46, carry=0, ovf=0.
- Add A=8'hFF, B=8'h01 -> SAT_MODE=0: sum=8'h00, carry=1, ovf=0; SAT_MODE=1: sum=8'hFF, carry=1. Add A=8'h7F, B=8'h01 -> sum=8'h80, ovf=1.
- Sub A=8'h05, B=8'h07 -> SAT_MODE=0: sum=8'hFE, carry(borrow)=1; SAT_MODE=1: sum=8'h00. Sub A=8'h80, B=8'h01 -> sum=8'h7F, ovf=1.
- Back-to-back stream of 16 beats with out_ready=1 -> one result per clock after latency 2, order preserved, scoreboard match.
- out_ready=0 after 1 beat, keep in_valid=1 -> in_ready stays 1 for one more beat (bubble collapse), then 0. Output data stable during stall; release -> 2 results drain in order, then in_ready returns to 1.
- Assert rst_n=0 with 2 beats in flight -> out_valid=0, busy=0 immediately (asynchronous); no stale result after release.
- STAGES=4, WIDTH=16 rerun of the stream test -> latency 4, full throughput.
